// File: rtl/core_config_pkg.sv
// Core configuration: data widths, CSR addresses,
// reset values and write masks for the machine CSR file.
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int CSR_ADDR_W = 12;

  typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  localparam csr_addr_t CSR_NONE      = 12'h000;
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MISA      = 12'h301;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_INSTRET   = 12'hC02;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;
  localparam csr_addr_t CSR_MIMPID    = 12'hF13;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  localparam xword_t MSTATUS_RST = 32'h0000_1800;
  localparam xword_t MISA_VAL    = 32'h4000_0100;
  localparam xword_t MIE_MASK    = 32'h0000_0888;
  localparam xword_t ALIGN4_MASK = 32'hFFFF_FFFC;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  function automatic logic csr_impl(csr_addr_t a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH,
      CSR_INSTRETH, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and per-half load.
// Ports: clk, rst, inc, we_lo, we_hi, wd -> cnt.
module csr_counter64
  import core_config_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              we_lo,
  input  logic              we_hi,
  input  logic [XLEN-1:0]   wd,
  output logic [2*XLEN-1:0] cnt
);

  // A load of either half suppresses the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (we_lo) begin
      cnt[XLEN-1:0] <= wd;
    end else if (we_hi) begin
      cnt[2*XLEN-1:XLEN] <= wd;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, trap/mret
// state, cycle/instret counters, registered irq_pending.
module csr_file
  import core_config_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CSR_ADDR_W-1:0] csr_ra,
  output logic [XLEN-1:0]       csr_rd,
  output logic                  csr_err,
  input  logic [CSR_ADDR_W-1:0] csr_wa,
  input  logic                  csr_we,
  input  logic [XLEN-1:0]       csr_wd,
  input  logic                  instr_retired,
  input  logic                  irq_ext,
  input  logic                  irq_timer,
  input  logic                  irq_sw,
  input  logic                  trap_en,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_val,
  input  logic                  mret,
  output logic [XLEN-1:0]       mtvec_o,
  output logic [XLEN-1:0]       mepc_o,
  output logic                  irq_pending
);

  mstatus_t          mst;
  logic [XLEN-1:0]   mie_q;
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mscratch_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [2*XLEN-1:0] mcycle;
  logic [2*XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_v;
  logic [XLEN-1:0] mip_v;
  logic            rd_err;
  logic            wr_err;
  logic            wr_ok;

  assign mstatus_v = {19'b0, 2'b11, 3'b0, mst.mpie,
                      3'b0, mst.mie, 3'b0};
  assign mip_v = {20'b0, irq_ext, 3'b0, irq_timer,
                  3'b0, irq_sw, 3'b0};

  // Counter/ID space (addr[11:10] == 2'b11) is read-only.
  assign rd_err = (csr_ra != CSR_NONE) && !csr_impl(csr_ra);
  assign wr_err = csr_we &&
                  (!csr_impl(csr_wa) ||
                   csr_wa[CSR_ADDR_W-1 -: 2] == 2'b11);
  assign wr_ok  = csr_we && !wr_err;
  assign csr_err = rd_err || wr_err;

  function automatic logic hit(csr_addr_t a);
    return wr_ok && (csr_wa == a);
  endfunction

  always_comb begin
    csr_rd = '0;
    case (csr_ra)
      CSR_MSTATUS:  csr_rd = mstatus_v;
      CSR_MISA:     csr_rd = MISA_VAL;
      CSR_MIE:      csr_rd = mie_q;
      CSR_MTVEC:    csr_rd = mtvec_q;
      CSR_MSCRATCH: csr_rd = mscratch_q;
      CSR_MEPC:     csr_rd = mepc_q;
      CSR_MCAUSE:   csr_rd = mcause_q;
      CSR_MTVAL:    csr_rd = mtval_q;
      CSR_MIP:      csr_rd = mip_v;
      CSR_MCYCLE,
      CSR_CYCLE:    csr_rd = mcycle[XLEN-1:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:   csr_rd = mcycle[2*XLEN-1:XLEN];
      CSR_MINSTRET,
      CSR_INSTRET:  csr_rd = minstret[XLEN-1:0];
      CSR_MINSTRETH,
      CSR_INSTRETH: csr_rd = minstret[2*XLEN-1:XLEN];
      default:      csr_rd = '0;
    endcase
  end

  // Trap has priority over mret and over CSR writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst <= '0;
    end else if (trap_en) begin
      mst.mpie <= mst.mie;
      mst.mie  <= 1'b0;
    end else if (mret) begin
      mst.mie  <= mst.mpie;
      mst.mpie <= 1'b1;
    end else if (hit(CSR_MSTATUS)) begin
      mst.mie  <= csr_wd[MSTATUS_MIE];
      mst.mpie <= csr_wd[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_en) begin
      mepc_q   <= trap_pc & ALIGN4_MASK;
      mcause_q <= trap_cause;
      mtval_q  <= trap_val;
    end else begin
      if (hit(CSR_MEPC))   mepc_q   <= csr_wd & ALIGN4_MASK;
      if (hit(CSR_MCAUSE)) mcause_q <= csr_wd;
      if (hit(CSR_MTVAL))  mtval_q  <= csr_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (hit(CSR_MIE))      mie_q      <= csr_wd & MIE_MASK;
      if (hit(CSR_MTVEC))    mtvec_q    <= csr_wd & ALIGN4_MASK;
      if (hit(CSR_MSCRATCH)) mscratch_q <= csr_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_pending <= 1'b0;
    else     irq_pending <= mst.mie && |(mip_v & mie_q);
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (hit(CSR_MCYCLE)),
    .we_hi (hit(CSR_MCYCLEH)),
    .wd    (csr_wd),
    .cnt   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retired),
    .we_lo (hit(CSR_MINSTRET)),
    .we_hi (hit(CSR_MINSTRETH)),
    .wd    (csr_wd),
    .cnt   (minstret)
  );

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: vector table for plain
// register access, directed sequences for counters/traps/irq.
module tb_csr_file;
  import core_config_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [11:0]     csr_ra = '0;
  logic [31:0]     csr_rd;
  logic            csr_err;
  logic [11:0]     csr_wa = '0;
  logic            csr_we = 1'b0;
  logic [31:0]     csr_wd = '0;
  logic            instr_retired = 1'b0;
  logic            irq_ext = 1'b0;
  logic            irq_timer = 1'b0;
  logic            irq_sw = 1'b0;
  logic            trap_en = 1'b0;
  logic [31:0]     trap_cause = '0;
  logic [31:0]     trap_pc = '0;
  logic [31:0]     trap_val = '0;
  logic            mret = 1'b0;
  logic [31:0]     mtvec_o;
  logic [31:0]     mepc_o;
  logic            irq_pending;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk           (clk),
    .rst           (rst),
    .csr_ra        (csr_ra),
    .csr_rd        (csr_rd),
    .csr_err       (csr_err),
    .csr_wa        (csr_wa),
    .csr_we        (csr_we),
    .csr_wd        (csr_wd),
    .instr_retired (instr_retired),
    .irq_ext       (irq_ext),
    .irq_timer     (irq_timer),
    .irq_sw        (irq_sw),
    .trap_en       (trap_en),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_val      (trap_val),
    .mret          (mret),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o),
    .irq_pending   (irq_pending)
  );

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    csr_we = 1'b1;
    csr_wa = a;
    csr_wd = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(string name, logic [11:0] a,
                    logic [31:0] exp);
    csr_ra = a;
    #1;
    chk(name, csr_rd, exp);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 12'h000, 32'h0, 12'hF14, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 32'h0, 12'h7C0, 32'h0, 1'b1};
    tbl[2]  = '{1'b0, 12'h000, 32'h0, 12'h300, 32'h1800, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 32'h0, 12'h301, 32'h40000100, 1'b0};
    tbl[4]  = '{1'b1, 12'h305, 32'hFFFFFFFF, 12'h305, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 32'h0, 12'h305, 32'hFFFFFFFC, 1'b0};
    tbl[6]  = '{1'b1, 12'h304, 32'hFFFFFFFF, 12'h304, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 32'h0, 12'h304, 32'h888, 1'b0};
    tbl[8]  = '{1'b1, 12'h340, 32'hDEADBEEF, 12'h340, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 32'h0, 12'h340, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{1'b1, 12'h341, 32'h12345677, 12'h341, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 32'h0, 12'h341, 32'h12345674, 1'b0};
    tbl[12] = '{1'b1, 12'h301, 32'h0, 12'h301, 32'h40000100, 1'b0};
    tbl[13] = '{1'b1, 12'hF11, 32'h5, 12'h000, 32'h0, 1'b1};
    tbl[14] = '{1'b0, 12'h000, 32'h0, 12'hF11, 32'h0, 1'b0};
    tbl[15] = '{1'b1, 12'h344, 32'hFFF, 12'h344, 32'h0, 1'b0};
    tbl[16] = '{1'b1, 12'h304, 32'h0, 12'h000, 32'h0, 1'b0};
    tbl[17] = '{1'b0, 12'h000, 32'h0, 12'h304, 32'h0, 1'b0};
    tbl[18] = '{1'b1, 12'h7C0, 32'h1, 12'h000, 32'h0, 1'b1};

    // reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_irq_pending", {31'b0, irq_pending}, 32'h0);
    chk("rst_mtvec_o", mtvec_o, 32'h0);

    // vector table
    foreach (tbl[i]) begin
      csr_we = tbl[i].we;
      csr_wa = tbl[i].wa;
      csr_wd = tbl[i].wd;
      csr_ra = tbl[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), csr_rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), {31'b0, csr_err},
          {31'b0, tbl[i].err});
      tick();
    end
    csr_we = 1'b0;
    chk("mtvec_o", mtvec_o, 32'hFFFFFFFC);
    chk("mepc_o", mepc_o, 32'h12345674);

    // read-only cycle alias: write rejected, counting goes on
    wr(12'hB00, 32'd100);
    csr_we = 1'b1;
    csr_wa = 12'hC00;
    csr_wd = 32'h0;
    rd("cycle_before", 12'hC00, 32'd100);
    chk("cycle_wr_err", {31'b0, csr_err}, 32'h1);
    tick();
    csr_we = 1'b0;
    rd("cycle_after", 12'hC00, 32'd101);

    // mcycle carry into high word; minstret frozen
    wr(12'hB02, 32'd7);
    wr(12'hB82, 32'd0);
    wr(12'hB00, 32'hFFFFFFFF);
    wr(12'hB80, 32'h0);
    tick();
    rd("mcycle_lo_carry", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h1);
    rd("instret_frozen", 12'hC02, 32'd7);
    instr_retired = 1'b1;
    tick();
    instr_retired = 1'b0;
    rd("instret_inc", 12'hC02, 32'd8);

    // minstret wrap with write-suppressed increment
    instr_retired = 1'b1;
    wr(12'hB02, 32'hFFFFFFFF);
    wr(12'hB82, 32'hFFFFFFFF);
    rd("instret_suppr_lo", 12'hB02, 32'hFFFFFFFF);
    tick();
    instr_retired = 1'b0;
    rd("instret_wrap_lo", 12'hB02, 32'h0);
    rd("instret_wrap_hi", 12'hB82, 32'h0);

    // mcycle wrap
    wr(12'hB00, 32'hFFFFFFFF);
    wr(12'hB80, 32'hFFFFFFFF);
    tick();
    rd("mcycle_wrap_lo", 12'hC00, 32'h0);
    rd("mcycle_wrap_hi", 12'hC80, 32'h0);

    // trap with concurrent mepc write and mret: trap wins
    wr(12'h300, 32'h8);
    rd("mstatus_mie", 12'h300, 32'h1808);
    trap_en = 1'b1;
    mret = 1'b1;
    trap_pc = 32'h103;
    trap_cause = 32'h8000000B;
    trap_val = 32'hABC;
    wr(12'h341, 32'h55555555);
    trap_en = 1'b0;
    mret = 1'b0;
    chk("trap_mepc_o", mepc_o, 32'h100);
    rd("trap_mcause", 12'h342, 32'h8000000B);
    rd("trap_mtval", 12'h343, 32'hABC);
    rd("trap_mstatus", 12'h300, 32'h1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h1888);

    // trap + mscratch write: mscratch write proceeds
    trap_en = 1'b1;
    trap_pc = 32'h200;
    wr(12'h340, 32'h77);
    trap_en = 1'b0;
    rd("trap_mscratch", 12'h340, 32'h77);
    chk("trap2_mepc_o", mepc_o, 32'h200);
    rd("trap2_mstatus", 12'h300, 32'h1880);

    // irq_pending latency
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    irq_ext = 1'b1;
    #1;
    chk("irq_pre", {31'b0, irq_pending}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq_pending}, 32'h1);
    rd("mip_ext", 12'h344, 32'h800);
    wr(12'h304, 32'h0);
    tick();
    chk("irq_clr", {31'b0, irq_pending}, 32'h0);
    irq_ext = 1'b0;

    // MIE gates the interrupt
    wr(12'h304, 32'h888);
    wr(12'h300, 32'h0);
    irq_timer = 1'b1;
    tick();
    tick();
    chk("irq_gated", {31'b0, irq_pending}, 32'h0);
    wr(12'h300, 32'h8);
    tick();
    chk("irq_timer", {31'b0, irq_pending}, 32'h1);

    // reset mid-operation with a write in flight
    csr_we = 1'b1;
    csr_wa = 12'h340;
    csr_wd = 32'h1234;
    csr_ra = 12'h340;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_irq", {31'b0, irq_pending}, 32'h0);
    chk("midrst_mscratch", csr_rd, 32'h0);
    rd("midrst_mstatus", 12'h300, 32'h1800);
    rd("midrst_err", 12'h7C0, 32'h0);
    chk("midrst_err_flag", {31'b0, csr_err}, 32'h1);
    tick();
    csr_we = 1'b0;
    irq_timer = 1'b0;
    rst = 1'b0;
    rd("postrst_mscratch", 12'h340, 32'h0);
    rd("postrst_mcycle0", 12'hB00, 32'h0);
    tick();
    rd("postrst_mcycle1", 12'hB00, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
